// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
// Holds the default multiply/divide latencies, the register-zero constant,
// the busy-counter width calculation and the stall-cause record.
package hazard_ctrl_pkg;

    localparam int         DEFAULT_MULT_CYCLES = 5;
    localparam int         DEFAULT_DIV_CYCLES  = 10;
    localparam logic [4:0] REG_ZERO            = 5'd0;
    localparam logic [31:0] STALL_CNT_MAX      = 32'hFFFF_FFFF;

    // One flag per independent reason the ID stage has to be held.
    typedef struct packed {
        logic loadUse;
        logic branchAlu;
        logic branchLoad;
        logic mdBusy;
    } stall_cause_t;

    // Busy counter must hold the longer of the two latencies, and is never
    // narrower than four bits.
    function automatic int cntWidth(input int multCycles, input int divCycles);
        int maxCycles;
        int width;
        maxCycles = (multCycles > divCycles) ? multCycles : divCycles;
        width     = $clog2(maxCycles + 1);
        return (width < 4) ? 4 : width;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_timer.sv
// HI/LO unit occupancy timer. A start loads the latency of the operation
// being launched (divide or multiply); the count then drains one per cycle.
// busy comes straight from the counter register, so it never depends
// combinationally on start.
module md_busy_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int CNT_W = cntWidth(MULT_CYCLES, DIV_CYCLES);

    logic [CNT_W-1:0] r_count;

    // Load on start (a restart beats the decrement), otherwise drain to zero;
    // reset aborts whatever operation is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign busy = (r_count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard detection for a five-stage MIPS-style core.
// Detects load-use, branch-operand (ALU and load producers) and HI/LO unit
// hazards and freezes PC and IF/ID while bubbling ID/EX.
// Optional feature: define HAZARD_STATS_EN to add the saturating Stall_Cnt
// output counting stalled cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        ID_UseRs,
    input  logic        ID_UseRt,
    input  logic        ID_IsBranch,
    input  logic        ID_IsMD,
    input  logic        EX_RegWrite,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_WriteReg,
    input  logic        MEM_MemRead,
    input  logic [4:0]  MEM_WriteReg,
    input  logic        EX_MDStart,
    input  logic        EX_MDIsDiv,
    output logic        PC_En,
    output logic        IF_ID_En,
    output logic        ID_EX_Clr,
    output logic        MD_Busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] Stall_Cnt
`endif
);

    logic         w_matchEx;
    logic         w_matchMem;
    stall_cause_t w_cause;
    logic         w_stall;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (EX_MDStart),
        .is_div (EX_MDIsDiv),
        .busy   (MD_Busy)
    );

    // Does the ID instruction read a register produced by EX or MEM? Register
    // zero is hardwired, so it never creates a dependency.
    always_comb begin
        w_matchEx  = (EX_WriteReg != REG_ZERO) &&
                     ((ID_UseRs && (ID_Rs == EX_WriteReg)) ||
                      (ID_UseRt && (ID_Rt == EX_WriteReg)));
        w_matchMem = (MEM_WriteReg != REG_ZERO) &&
                     ((ID_UseRs && (ID_Rs == MEM_WriteReg)) ||
                      (ID_UseRt && (ID_Rt == MEM_WriteReg)));
    end

    // Collect every hazard reason; reset suppresses the stall so the front
    // end keeps flowing while the core is being initialised.
    always_comb begin
        w_cause.loadUse    = EX_MemRead && w_matchEx;
        w_cause.branchAlu  = ID_IsBranch && EX_RegWrite && w_matchEx;
        w_cause.branchLoad = ID_IsBranch && MEM_MemRead && w_matchMem;
        w_cause.mdBusy     = ID_IsMD && (MD_Busy || EX_MDStart);
        w_stall            = !reset && (|w_cause);
    end

    assign PC_En     = !w_stall;
    assign IF_ID_En  = !w_stall;
    assign ID_EX_Clr = w_stall;

`ifdef HAZARD_STATS_EN
    logic [31:0] r_stallCnt;

    // Count stalled cycles, sticking at the maximum instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt <= '0;
        end else if (w_stall && (r_stallCnt != STALL_CNT_MAX)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign Stall_Cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Inputs are changed 1 ns after each
// rising edge and outputs are sampled 2 ns later, well away from the edge.
// Define HAZARD_STATS_EN to also exercise the stall counter.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  ID_Rs;
    logic [4:0]  ID_Rt;
    logic        ID_UseRs;
    logic        ID_UseRt;
    logic        ID_IsBranch;
    logic        ID_IsMD;
    logic        EX_RegWrite;
    logic        EX_MemRead;
    logic [4:0]  EX_WriteReg;
    logic        MEM_MemRead;
    logic [4:0]  MEM_WriteReg;
    logic        EX_MDStart;
    logic        EX_MDIsDiv;
    logic        PC_En;
    logic        IF_ID_En;
    logic        ID_EX_Clr;
    logic        MD_Busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] Stall_Cnt;
`endif

    int checks;
    int errors;

    hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .ID_UseRs     (ID_UseRs),
        .ID_UseRt     (ID_UseRt),
        .ID_IsBranch  (ID_IsBranch),
        .ID_IsMD      (ID_IsMD),
        .EX_RegWrite  (EX_RegWrite),
        .EX_MemRead   (EX_MemRead),
        .EX_WriteReg  (EX_WriteReg),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_WriteReg (MEM_WriteReg),
        .EX_MDStart   (EX_MDStart),
        .EX_MDIsDiv   (EX_MDIsDiv),
        .PC_En        (PC_En),
        .IF_ID_En     (IF_ID_En),
        .ID_EX_Clr    (ID_EX_Clr),
        .MD_Busy      (MD_Busy)
`ifdef HAZARD_STATS_EN
        ,
        .Stall_Cnt    (Stall_Cnt)
`endif
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic setIdle();
        reset        = 1'b0;
        ID_Rs        = 5'd0;
        ID_Rt        = 5'd0;
        ID_UseRs     = 1'b0;
        ID_UseRt     = 1'b0;
        ID_IsBranch  = 1'b0;
        ID_IsMD      = 1'b0;
        EX_RegWrite  = 1'b0;
        EX_MemRead   = 1'b0;
        EX_WriteReg  = 5'd0;
        MEM_MemRead  = 1'b0;
        MEM_WriteReg = 5'd0;
        EX_MDStart   = 1'b0;
        EX_MDIsDiv   = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        setIdle();
        reset      = 1'b1;
        EX_MemRead = 1'b1;
        EX_WriteReg = 5'd8;
        ID_UseRs   = 1'b1;
        ID_Rs      = 5'd8;
        nextCycle();
        nextCycle();
        #2;
        checks++;
        if (MD_Busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_md_busy got %b want 0", MD_Busy);
        end
        checks++;
        if ({PC_En, IF_ID_En, ID_EX_Clr} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL reset_forces_no_stall got %b want 110",
                     {PC_En, IF_ID_En, ID_EX_Clr});
        end
        setIdle();
        nextCycle();
    endtask

    task automatic test_load_use();
        setIdle();
        EX_MemRead  = 1'b1;
        EX_WriteReg = 5'd8;
        ID_UseRs    = 1'b1;
        ID_Rs       = 5'd8;
        #2;
        checks++;
        if ({PC_En, IF_ID_En, ID_EX_Clr} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL load_use_rs got %b want 001", {PC_En, IF_ID_En, ID_EX_Clr});
        end
        nextCycle();
        EX_MemRead = 1'b0;
        #2;
        checks++;
        if ({PC_En, IF_ID_En, ID_EX_Clr} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL load_use_release got %b want 110", {PC_En, IF_ID_En, ID_EX_Clr});
        end
        nextCycle();
        setIdle();
        EX_MemRead  = 1'b1;
        EX_WriteReg = 5'd17;
        ID_UseRt    = 1'b1;
        ID_Rt       = 5'd17;
        ID_Rs       = 5'd17;
        #2;
        checks++;
        if (ID_EX_Clr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL load_use_rt got %b want 1", ID_EX_Clr);
        end
        ID_UseRt = 1'b0;
        #1;
        checks++;
        if (ID_EX_Clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_use_unused_src got %b want 0", ID_EX_Clr);
        end
        nextCycle();
        setIdle();
    endtask

    task automatic test_reg_zero();
        setIdle();
        EX_MemRead  = 1'b1;
        EX_WriteReg = 5'd0;
        ID_UseRs    = 1'b1;
        ID_Rs       = 5'd0;
        ID_IsBranch = 1'b1;
        EX_RegWrite = 1'b1;
        MEM_MemRead = 1'b1;
        #2;
        checks++;
        if ({PC_En, IF_ID_En, ID_EX_Clr} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL reg_zero_no_stall got %b want 110", {PC_En, IF_ID_En, ID_EX_Clr});
        end
        nextCycle();
        setIdle();
    endtask

    task automatic test_branch();
        setIdle();
        ID_IsBranch = 1'b1;
        ID_Rt       = 5'd9;
        ID_UseRt    = 1'b1;
        EX_RegWrite = 1'b1;
        EX_WriteReg = 5'd9;
        #2;
        checks++;
        if (PC_En !== 1'b0) begin
            errors++;
            $display("[TB] FAIL branch_alu got PC_En %b want 0", PC_En);
        end
        nextCycle();
        EX_RegWrite  = 1'b0;
        EX_WriteReg  = 5'd0;
        MEM_MemRead  = 1'b1;
        MEM_WriteReg = 5'd9;
        #2;
        checks++;
        if ({PC_En, IF_ID_En, ID_EX_Clr} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL branch_load got %b want 001", {PC_En, IF_ID_En, ID_EX_Clr});
        end
        ID_IsBranch = 1'b0;
        EX_RegWrite = 1'b1;
        EX_WriteReg = 5'd9;
        #1;
        checks++;
        if (ID_EX_Clr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL non_branch_alu_dep got %b want 0", ID_EX_Clr);
        end
        nextCycle();
        setIdle();
    endtask

    // Launch one operation at cycle 0 with ID_IsMD held and compare every
    // cycle against the expected busy window [1, lastBusy].
    task automatic test_md_op(input logic isDiv, input int lastBusy);
        logic expBusy;
        logic expStall;
        setIdle();
        for (int c = 0; c <= lastBusy + 2; c++) begin
            ID_IsMD    = 1'b1;
            EX_MDStart = (c == 0);
            EX_MDIsDiv = isDiv;
            #2;
            expBusy  = (c >= 1) && (c <= lastBusy);
            expStall = (c <= lastBusy);
            checks++;
            if (MD_Busy !== expBusy) begin
                errors++;
                $display("[TB] FAIL md_busy div=%0b cycle %0d got %b want %b",
                         isDiv, c, MD_Busy, expBusy);
            end
            checks++;
            if (ID_EX_Clr !== expStall) begin
                errors++;
                $display("[TB] FAIL md_stall div=%0b cycle %0d got %b want %b",
                         isDiv, c, ID_EX_Clr, expStall);
            end
            nextCycle();
        end
        setIdle();
    endtask

    task automatic test_md_restart();
        logic expBusy;
        setIdle();
        for (int c = 0; c <= 10; c++) begin
            EX_MDStart = (c == 0) || (c == 3);
            EX_MDIsDiv = (c == 0);
            #2;
            expBusy = (c >= 1) && (c <= 8);
            checks++;
            if (MD_Busy !== expBusy) begin
                errors++;
                $display("[TB] FAIL md_restart cycle %0d got %b want %b", c, MD_Busy, expBusy);
            end
            nextCycle();
        end
        setIdle();
    endtask

    task automatic test_reset_abort();
        setIdle();
        for (int c = 0; c <= 6; c++) begin
            ID_IsMD    = 1'b1;
            EX_MDStart = (c == 0);
            EX_MDIsDiv = 1'b1;
            reset      = (c == 4);
            #2;
            if (c == 4) begin
                checks++;
                if ({PC_En, IF_ID_En, ID_EX_Clr} !== 3'b110) begin
                    errors++;
                    $display("[TB] FAIL reset_during_md got %b want 110",
                             {PC_En, IF_ID_En, ID_EX_Clr});
                end
            end
            if (c >= 5) begin
                checks++;
                if ({MD_Busy, ID_EX_Clr} !== 2'b00) begin
                    errors++;
                    $display("[TB] FAIL reset_abort cycle %0d got %b want 00",
                             c, {MD_Busy, ID_EX_Clr});
                end
`ifdef HAZARD_STATS_EN
                checks++;
                if (Stall_Cnt !== 32'd0) begin
                    errors++;
                    $display("[TB] FAIL reset_abort_cnt got %0d want 0", Stall_Cnt);
                end
`endif
            end
            nextCycle();
        end
        setIdle();
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        setIdle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            EX_MemRead  = 1'b1;
            EX_WriteReg = 5'd8;
            ID_UseRs    = 1'b1;
            ID_Rs       = 5'd8;
            nextCycle();
        end
        setIdle();
        #2;
        checks++;
        if (Stall_Cnt !== 32'd3) begin
            errors++;
            $display("[TB] FAIL stall_cnt_three got %0d want 3", Stall_Cnt);
        end
        nextCycle();
        dut.r_stallCnt = 32'hFFFF_FFFE;
        for (int c = 0; c < 3; c++) begin
            EX_MemRead  = 1'b1;
            EX_WriteReg = 5'd8;
            ID_UseRs    = 1'b1;
            ID_Rs       = 5'd8;
            nextCycle();
        end
        setIdle();
        #2;
        checks++;
        if (Stall_Cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("[TB] FAIL stall_cnt_saturate got %h want ffffffff", Stall_Cnt);
        end
        nextCycle();
    endtask
`endif

    // Run every scenario in order and report.
    initial begin
        checks = 0;
        errors = 0;
        setIdle();
        #1;
        test_reset();
        test_load_use();
        test_reg_zero();
        test_branch();
        test_md_op(1'b1, 10);
        test_md_op(1'b0, 5);
        test_md_restart();
        test_reset_abort();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles after a mult/multu start.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles after a div/divu start.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ID_Rs, ID_Rt  input  5 each  source register numbers of the instruction in ID.
REQ-006 ID_UseRs, ID_UseRt  input  1 each  ID instruction reads Rs / Rt.
REQ-007 ID_IsBranch  input  1  ID instruction is a branch/jr/jalr (operands needed in ID).
REQ-008 ID_IsMD  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-009 EX_RegWrite, EX_MemRead  input  1 each  EX instruction writes GPR / is a load.
REQ-010 EX_WriteReg  input  5  EX destination register.
REQ-011 MEM_MemRead  input  1  MEM instruction is a load; MEM_WriteReg  input  5  its destination.
REQ-012 EX_MDStart, EX_MDIsDiv  input  1 each  mult/div starts this cycle in EX; 1 = divide.
REQ-013 PC_En  output  1  PC write enable; IF_ID_En  output  1  IF/ID register enable.
REQ-014 ID_EX_Clr  output  1  synchronous bubble insert into ID/EX.
REQ-015 MD_Busy  output  1  HI/LO unit occupied.
REQ-016 Stall_Cnt  output  32  stall-cycle count (present only with HAZARD_STATS_EN).

Function
REQ-017 Match(r) SHALL mean r != 0 and ((ID_UseRs and ID_Rs == r) or (ID_UseRt and ID_Rt == r)).
REQ-018 Load-use stall SHALL assert when EX_MemRead and Match(EX_WriteReg).
REQ-019 Branch-ALU stall SHALL assert when ID_IsBranch and EX_RegWrite and Match(EX_WriteReg).
REQ-020 Branch-load stall SHALL assert when ID_IsBranch and MEM_MemRead and Match(MEM_WriteReg).
REQ-021 MD stall SHALL assert when ID_IsMD and (MD_Busy or EX_MDStart).
REQ-022 Stall SHALL be the OR of REQ-018..021, combinational, same cycle as inputs.
REQ-023 Stall=1 SHALL drive PC_En=0, IF_ID_En=0, ID_EX_Clr=1; Stall=0 SHALL drive 1, 1, 0.
REQ-024 Busy counter (4 bits minimum, width from max(MULT_CYCLES,DIV_CYCLES)) SHALL load DIV_CYCLES or MULT_CYCLES per EX_MDIsDiv on a cycle with EX_MDStart.
REQ-025 Without EX_MDStart, counter SHALL decrement by 1 per cycle when nonzero and hold at 0.
REQ-026 MD_Busy SHALL equal (counter != 0), registered-state-derived, no combinational path from EX_MDStart.
REQ-027 EX_MDStart while counter nonzero SHALL reload (restart wins over decrement).
REQ-028 Register 0 SHALL never cause a stall.

Reset
REQ-029 reset=1 at posedge SHALL clear counter (MD_Busy=0) and Stall_Cnt to 0, aborting any in-flight mult/div count.
REQ-030 While reset=1, Stall SHALL be forced 0 (PC_En=1, IF_ID_En=1, ID_EX_Clr=0).

Configuration
REQ-031 Macro HAZARD_STATS_EN defined: Stall_Cnt port and register exist, increment by 1 each cycle with Stall=1, saturate at 32'hFFFF_FFFF.
REQ-032 HAZARD_STATS_EN undefined: Stall_Cnt port and register absent; all other behaviour identical.

Structure
REQ-033 Shared package SHALL hold default MULT_CYCLES/DIV_CYCLES constants and register-zero constant.
REQ-034 Busy counter SHALL be sub-module md_busy_timer (inputs start, is_div; output busy); stall logic stays in hazard_ctrl.

Verification
REQ-035 EX_MemRead=1, EX_WriteReg=8, ID_UseRs=1, ID_Rs=8 -> PC_En=0, IF_ID_En=0, ID_EX_Clr=1 that cycle; next cycle EX_MemRead=0 -> all released.
REQ-036 Same as REQ-035 with EX_WriteReg=0, ID_Rs=0 -> no stall.
REQ-037 ID_IsBranch=1, ID_Rt=9, ID_UseRt=1, EX_RegWrite=1, EX_WriteReg=9 -> stall 1 cycle; then MEM_MemRead=1, MEM_WriteReg=9 -> stall again.
REQ-038 EX_MDStart=1, EX_MDIsDiv=1 at cycle 0, ID_IsMD=1 held -> MD_Busy=1 cycles 1..10, stall cycles 0..10, released cycle 11; with MDIsDiv=0 release at cycle 6.
REQ-039 Div started, reset=1 at cycle 4 -> MD_Busy=0 and Stall_Cnt=0 from cycle 5.
REQ-040 HAZARD_STATS_EN: 3 load-use stall cycles -> Stall_Cnt=3; preload near saturation -> holds 32'hFFFF_FFFF.
